hex_msg_scroller: RTL and testbench

Upstream stage of the per-digit 7-segment decoders (one ssdN per HEX digit). Holds a fixed message of 4-bit character codes and drives one code per HEX digit, scrolling a NUM_DIGITS-wide window across the message. Scrolling runs on a prescaled tick or by single-step. Outputs feed the ssdN `in` ports directly; decoders stay purely combinational.

---
 rtl/hex_msg_pkg.sv | 39 +++
 rtl/msg_rom.sv | 16 +
 rtl/hex_msg_scroller.sv | 144 ++++++++++++++
 tb/tb_hex_msg_scroller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_msg_pkg.sv
// -----------------------------------------------------------------------------
// hex_msg_pkg
// Shared definitions for the HEX message scroller:
//   state_t      - scroller FSM states (IDLE, RUN, HOLD)
//   BLANK_CODE   - character code the 7-segment decoders show as all-off
//   DEFAULT_MSG  - message ROM contents, one 4-bit character code per entry
//   wrap_add     - modular index add for indices below 16
// -----------------------------------------------------------------------------
package hex_msg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   localparam int unsigned MSG_MAX = 16;

   // Only the first MSG_LEN entries are ever addressed.
   localparam logic [3:0] DEFAULT_MSG [MSG_MAX] = '{
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF
   };

   // (base + offs) mod len, for base < len and offs < len. The sum is formed
   // in 5 bits so it cannot overflow; a single conditional subtract is then
   // enough because the sum is always below 2*len.
   function automatic logic [3:0] wrap_add(input logic [3:0] base,
                                           input logic [4:0] offs,
                                           input logic [4:0] len);
      logic [4:0] sum;
      sum = {1'b0, base} + offs;
      if (sum >= len) sum = sum - len;
      return sum[3:0];
   endfunction

endpackage

// File: rtl/msg_rom.sv
// -----------------------------------------------------------------------------
// msg_rom
// Combinational message lookup; one instance per digit lane.
//   idx  in   4  character index into the message
//   code out  4  character code at that index
// -----------------------------------------------------------------------------
module msg_rom
   import hex_msg_pkg::*;
(
   input  logic [3:0] idx,
   output logic [3:0] code
);

   assign code = DEFAULT_MSG[idx];

endmodule

// File: rtl/hex_msg_scroller.sv
// -----------------------------------------------------------------------------
// hex_msg_scroller
// Scrolls a NUM_DIGITS-wide window across a fixed message and drives one
// 4-bit character code per HEX digit (feeds the ssdN decoders directly).
//   clk     in   1             system clock
//   reset   in   1             asynchronous, active-high reset
//   enable  in   1             1 = auto-scroll, 0 = freeze (HOLD)
//   clear   in   1             synchronous return to IDLE, pos 0, blank
//   dir     in   1             0 = advance (+1), 1 = retreat (-1)
//   step    in   1             asynchronous pushbutton, single-step in HOLD
//   codes   out  4*NUM_DIGITS  digit k in [4k+3:4k]; digit 0 = HEX0 (right)
//   pos     out  4             window start index, 0..MSG_LEN-1
//   wrap    out  1             one-cycle pulse when pos wraps around
// -----------------------------------------------------------------------------
module hex_msg_scroller
   import hex_msg_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 50_000_000,
   parameter int unsigned MSG_LEN    = 8,
   parameter int unsigned NUM_DIGITS = 6,
   parameter logic [3:0]  BLANK_CODE = hex_msg_pkg::BLANK_CODE
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    clear,
   input  logic                    dir,
   input  logic                    step,
   output logic [4*NUM_DIGITS-1:0] codes,
   output logic [3:0]              pos,
   output logic                    wrap
);

   localparam int unsigned           PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0]         TERM      = PW'(TICK_DIV - 1);
   localparam logic [4:0]            LEN       = 5'(MSG_LEN);
   localparam logic [3:0]            LAST_POS  = 4'(MSG_LEN - 1);
   localparam logic [4*NUM_DIGITS-1:0] BLANK_ROW = {NUM_DIGITS{BLANK_CODE}};

   state_t                  state;
   logic [PW-1:0]           presc;
   logic                    step_meta;
   logic                    step_sync;
   logic                    step_prev;
   logic                    tick;
   logic                    step_edge;
   logic                    advance;
   logic [3:0]              pos_next;
   logic                    wrap_hit;
   logic [4*NUM_DIGITS-1:0] window;

   // ---------------------------------------------------------------------------
   // Window lanes: leftmost digit shows rom[pos], each digit to the right shows
   // the next character, wrapping around the end of the message.
   // ---------------------------------------------------------------------------
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
      logic [3:0] idx;
      logic [3:0] code;

      assign idx = wrap_add(pos, 5'(NUM_DIGITS - 1 - k), LEN);

      msg_rom u_rom (
         .idx  (idx),
         .code (code)
      );

      assign window[4*k +: 4] = code;
   end

   // ---------------------------------------------------------------------------
   // Advance decode
   // ---------------------------------------------------------------------------
   assign tick      = (state == RUN) && (presc == TERM);
   // Only edges seen while frozen count; a step in RUN or IDLE is dropped.
   assign step_edge = step_sync & ~step_prev;
   assign advance   = tick || ((state == HOLD) && step_edge);

   assign pos_next  = dir ? wrap_add(pos, LEN - 5'd1, LEN)
                          : wrap_add(pos, 5'd1, LEN);

   // With a two-entry message every move crosses the boundary; only the
   // 0 -> last direction is reported in that case.
   assign wrap_hit  = ((pos == 4'd0) && (pos_next == LAST_POS)) ||
                      ((MSG_LEN > 2) && (pos == LAST_POS) && (pos_next == 4'd0));

   // ---------------------------------------------------------------------------
   // State, prescaler, position, outputs
   // ---------------------------------------------------------------------------
   // NOTE: every register here is updated with <= so all right-hand sides see
   // pre-edge values; a blocking = would let later statements see new values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         presc     <= '0;
         pos       <= '0;
         wrap      <= 1'b0;
         codes     <= BLANK_ROW;
         step_meta <= 1'b0;
         step_sync <= 1'b0;
         step_prev <= 1'b0;
      end else begin
         // Two-flop synchronizer for the asynchronous pushbutton, then the
         // previous-value register for edge detection. Keeps running through
         // clear so a held button never produces a spurious edge afterwards.
         step_meta <= step;
         step_sync <= step_meta;
         step_prev <= step_sync;

         wrap <= 1'b0;

         if (clear) begin
            state <= IDLE;
            presc <= '0;
            pos   <= '0;
            codes <= BLANK_ROW;
         end else begin
            // Built from the pre-edge pos, so codes trails pos by one cycle.
            codes <= (state == IDLE) ? BLANK_ROW : window;

            if (advance) begin
               pos  <= pos_next;
               wrap <= wrap_hit;
            end

            unique case (state)
               IDLE: begin
                  if (enable) state <= RUN;
               end
               RUN: begin
                  // The count runs in the cycle enable drops, so a tick that
                  // lands there still advances before HOLD freezes things.
                  presc <= tick ? '0 : presc + 1'b1;
                  if (!enable) state <= HOLD;
               end
               HOLD: begin
                  if (enable) state <= RUN;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hex_msg_scroller.sv
// -----------------------------------------------------------------------------
// tb_hex_msg_scroller
// Self-checking bench for hex_msg_scroller with TICK_DIV=4, MSG_LEN=8,
// NUM_DIGITS=6 and the identity message rom[i] = i.
// -----------------------------------------------------------------------------
module tb_hex_msg_scroller;

   localparam int TD = 4;
   localparam int ML = 8;
   localparam int ND = 6;

   logic            clk = 1'b0;
   logic            reset;
   logic            enable;
   logic            clear;
   logic            dir;
   logic            step;
   logic [4*ND-1:0] codes;
   logic [3:0]      pos;
   logic            wrap;

   always #5 clk = ~clk;

   hex_msg_scroller #(
      .TICK_DIV   (TD),
      .MSG_LEN    (ML),
      .NUM_DIGITS (ND),
      .BLANK_CODE (4'hF)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (clear),
      .dir    (dir),
      .step   (step),
      .codes  (codes),
      .pos    (pos),
      .wrap   (wrap)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: cycle budget expired", name);
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: modes 0 idle / 1 run / 2 hold, tick count modulo TD,
   // position modulo ML, step history as the last three clock samples.
   // ---------------------------------------------------------------------------
   int m_mode, m_cnt, m_pos, m_src;
   bit m_wrap;
   bit m_hist [3];

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_pos = 0; m_src = -1; m_wrap = 0;
      m_hist = '{0, 0, 0};
   endtask

   // Applied at each rising edge with the inputs that were stable there.
   task automatic model_edge();
      bit tick, sedge, adv;
      int np;
      tick  = (m_mode == 1) && (m_cnt == TD - 1);
      // A press acts on the third edge after it rises: sample two edges ago
      // high, sample three edges ago low.
      sedge = m_hist[1] && !m_hist[2];
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = step;
      m_wrap = 0;
      if (clear) begin
         m_mode = 0; m_cnt = 0; m_pos = 0; m_src = -1;
      end else begin
         m_src = (m_mode == 0) ? -1 : m_pos;
         adv = tick || (m_mode == 2 && sedge);
         if (adv) begin
            np = dir ? (m_pos + ML - 1) % ML : (m_pos + 1) % ML;
            m_wrap = (m_pos == 0 && np == ML - 1) || (ML > 2 && m_pos == ML - 1 && np == 0);
            m_pos = np;
         end
         case (m_mode)
            0: if (enable) m_mode = 1;
            1: begin
               m_cnt = (m_cnt + 1) % TD;
               if (!enable) m_mode = 2;
            end
            default: if (enable) m_mode = 1;
         endcase
      end
   endtask

   // Expected digit row for window start p; p < 0 means blank.
   function automatic logic [4*ND-1:0] window_of(input int p);
      logic [4*ND-1:0] v;
      for (int k = 0; k < ND; k++)
         v[4*k +: 4] = (p < 0) ? 4'hF : 4'((p + (ND - 1 - k)) % ML);
      return v;
   endfunction

   // Called at a falling edge: drive, take one rising edge, return at the
   // next falling edge where outputs are sampled.
   task automatic cyc(input bit en, input bit clr, input bit d, input bit st);
      enable = en; clear = clr; dir = d; step = st;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      check({tag, ".pos"},   32'(pos),   32'(m_pos));
      check({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
      check({tag, ".codes"}, 32'(codes), 32'(window_of(m_src)));
   endtask

   // Keep running forward until the model reaches the requested point in RUN
   // (negative target = don't care).
   task automatic run_until(input int tpos, input int tcnt, input bit d, input string tag);
      for (int i = 0; i < 200; i++) begin
         if (m_mode == 1 && (tpos < 0 || m_pos == tpos) && (tcnt < 0 || m_cnt == tcnt)) return;
         cyc(1, 0, d, 0);
         check_model(tag);
      end
      timeout(tag);
   endtask

   typedef struct {
      bit          en;
      bit          clr;
      logic [3:0]  pos;
      bit          wrap;
      logic [23:0] codes;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int p0;
      bit seen;
      bit en_r;
      bit st_r;

      // Start-up table, hand-derived: enter RUN, first window, two ticks,
      // then a clear and a fresh start.
      tbl[0]  = '{1, 0, 4'd0, 0, 24'hFFFFFF};
      tbl[1]  = '{1, 0, 4'd0, 0, 24'h012345};
      tbl[2]  = '{1, 0, 4'd0, 0, 24'h012345};
      tbl[3]  = '{1, 0, 4'd0, 0, 24'h012345};
      tbl[4]  = '{1, 0, 4'd1, 0, 24'h012345};
      tbl[5]  = '{1, 0, 4'd1, 0, 24'h123456};
      tbl[6]  = '{1, 0, 4'd1, 0, 24'h123456};
      tbl[7]  = '{1, 0, 4'd1, 0, 24'h123456};
      tbl[8]  = '{1, 0, 4'd2, 0, 24'h123456};
      tbl[9]  = '{1, 0, 4'd2, 0, 24'h234567};
      tbl[10] = '{1, 1, 4'd0, 0, 24'hFFFFFF};
      tbl[11] = '{1, 0, 4'd0, 0, 24'hFFFFFF};
      tbl[12] = '{1, 0, 4'd0, 0, 24'h012345};

      reset = 1'b1; enable = 0; clear = 0; dir = 0; step = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset.pos",   32'(pos),   32'd0);
      check("reset.wrap",  32'(wrap),  32'd0);
      check("reset.codes", 32'(codes), 32'hFFFFFF);
      reset = 1'b0;
      cyc(0, 0, 0, 0);
      check("idle.codes", 32'(codes), 32'hFFFFFF);

      for (int i = 0; i < 13; i++) begin
         cyc(tbl[i].en, tbl[i].clr, 0, 0);
         check($sformatf("tbl%0d.pos", i),   32'(pos),   32'(tbl[i].pos));
         check($sformatf("tbl%0d.wrap", i),  32'(wrap),  32'(tbl[i].wrap));
         check($sformatf("tbl%0d.codes", i), 32'(codes), 32'(tbl[i].codes));
      end

      // Forward wrap 7 -> 0.
      run_until(7, -1, 0, "fwd");
      seen = 0;
      for (int i = 0; i < 2 * TD + 2 && !seen; i++) begin
         cyc(1, 0, 0, 0);
         check_model("fwd");
         seen = (pos == 4'd0);
      end
      if (!seen) timeout("fwd.reach0");
      check("fwd.wrap_hi",  32'(wrap),  32'd1);
      check("fwd.codes7",   32'(codes), 32'h701234);
      cyc(1, 0, 0, 0);
      check("fwd.wrap_lo",  32'(wrap),  32'd0);
      check("fwd.codes0",   32'(codes), 32'h012345);

      // Backward wrap 0 -> 7.
      seen = 0;
      for (int i = 0; i < 2 * TD + 2 && !seen; i++) begin
         cyc(1, 0, 1, 0);
         check_model("rev");
         seen = (pos != 4'd0);
      end
      if (!seen) timeout("rev.leave0");
      check("rev.pos",     32'(pos),   32'd7);
      check("rev.wrap_hi", 32'(wrap),  32'd1);
      cyc(1, 0, 1, 0);
      check("rev.codes",   32'(codes), 32'h701234);
      check("rev.wrap_lo", 32'(wrap),  32'd0);

      // Freeze with the count at 2, hold 20 cycles, resume.
      run_until(-1, 2, 0, "hold");
      p0 = int'(pos);
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0, 0);
         check_model("hold");
      end
      check("hold.pos", 32'(pos), 32'(p0));
      cyc(1, 0, 0, 0);
      check("resume1.pos", 32'(pos), 32'(p0));
      cyc(1, 0, 0, 0);
      check("resume2.pos", 32'(pos), 32'((p0 + 1) % ML));

      // Held step in HOLD: one advance, on the third edge.
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      check_model("prestep");
      p0 = int'(pos);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 1);
         check($sformatf("step%0d.pos", i), 32'(pos), 32'(i >= 2 ? (p0 + 1) % ML : p0));
      end
      repeat (3) begin
         cyc(0, 0, 0, 0);
         check_model("steprel");
      end

      // Step pulse in RUN: 16 RUN edges give exactly four ticks, nothing more.
      cyc(1, 0, 0, 0);
      check_model("runstep");
      p0 = int'(pos);
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, 0, (i == 2 || i == 3));
         check_model("runstep");
      end
      check("runstep.pos", 32'(pos), 32'((p0 + 4) % ML));

      // clear in the same cycle as a wrapping tick.
      run_until(7, TD - 1, 0, "clr");
      cyc(1, 1, 0, 0);
      check("clr.pos",   32'(pos),   32'd0);
      check("clr.wrap",  32'(wrap),  32'd0);
      check("clr.codes", 32'(codes), 32'hFFFFFF);
      cyc(0, 0, 0, 0);
      check("clr.idle",  32'(codes), 32'hFFFFFF);

      // Asynchronous reset in the middle of a RUN cycle.
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 0, 0);
         check_model("prerst");
      end
      #2 reset = 1'b1;
      #1;
      check("arst.pos",   32'(pos),   32'd0);
      check("arst.wrap",  32'(wrap),  32'd0);
      check("arst.codes", 32'(codes), 32'hFFFFFF);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Randomized traffic against the model.
      en_r = 1;
      st_r = 0;
      for (int i = 0; i < 600; i++) begin
         if (i % 8 == 0) en_r = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 3) == 0) st_r = ~st_r;
         cyc(en_r, ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), st_r);
         check_model("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
